pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/instruction width.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports ICACHE_stall / DCACHE_stall  in  1 each: cache busy.
REQ-005 SHALL have ports ID_rs1 / ID_rs2  in  5 each: source registers of the instruction in ID.
REQ-006 SHALL have ports EX_rd  in  5 and EX_mem_read  in  1: destination register and load flag of the instruction in EX.
REQ-007 SHALL have ports ID_instruction  in  XLEN and branch_taken  in  1 and branch_target  in  XLEN: ID instruction, 1-cycle resolved-taken pulse, and target.
REQ-008 SHALL have ports memory_stall, PC_write, IF_flush, PC_src  out  1 each, and branch_address  out  XLEN: fetch-stage controls.
REQ-009 SHALL have port IF_DWrite  out  XLEN: instruction replayed into IF/ID during a load-use stall.
REQ-010 SHALL have ports perf_stall_cyc, perf_lu_cnt, perf_flush_cnt  out  32 each.

Function
REQ-011 SHALL drive memory_stall = ICACHE_stall | DCACHE_stall combinationally, zero latency.
REQ-012 SHALL define load-use hit = EX_mem_read & (EX_rd != 0) & (EX_rd == ID_rs1 | EX_rd == ID_rs2).
REQ-013 SHALL implement FSM RUN, LU_STALL, BR_PEND; reset state RUN.
REQ-014 RUN->LU_STALL on load-use hit with memory_stall=0 and no branch to issue; PC_write=1 that cycle, IF_DWrite=ID_instruction registered into lu_inst.
REQ-015 LU_STALL SHALL last exactly one cycle, then return to RUN; hit detection masked in LU_STALL (no back-to-back stall on the same pair).
REQ-016 IF_DWrite SHALL equal ID_instruction when PC_write=1, else lu_inst (held value); lu_inst resets to 32'h00000013.
REQ-017 branch_taken with memory_stall=0 SHALL assert PC_src=1, IF_flush=1, branch_address=branch_target in the same cycle, exactly one cycle.
REQ-018 branch_taken with memory_stall=1 SHALL latch target into pend_addr, go to BR_PEND; PC_src/IF_flush stay 0 while memory_stall=1.
REQ-019 In BR_PEND, first cycle with memory_stall=0 SHALL assert PC_src=1, IF_flush=1, branch_address=pend_addr for one cycle, then go to RUN.
REQ-020 A new branch_taken while in BR_PEND SHALL overwrite pend_addr (youngest wins).
REQ-021 Branch issue and load-use hit in the same cycle: branch wins, PC_write=0, state to RUN.
REQ-022 While memory_stall=1, PC_write=0 and FSM SHALL hold LU_STALL/RUN unchanged except REQ-018 transitions.
REQ-023 branch_address SHALL be 0 when PC_src=0.

Reset
REQ-024 On rst_n=0 (any cycle, mid-stall or mid-pending) SHALL immediately clear: state RUN, pend_addr 0, lu_inst 32'h00000013, PC_write/IF_flush/PC_src 0, counters 0.
REQ-025 memory_stall SHALL still reflect cache inputs during reset.

Configuration
REQ-026 Macro HAZ_PERF_CNT_EN defined: perf_stall_cyc counts cycles with memory_stall=1, perf_lu_cnt counts PC_write pulses, perf_flush_cnt counts IF_flush pulses; all saturate at 32'hFFFFFFFF.
REQ-027 Macro undefined: counter logic absent, three perf outputs tied to 0, ports retained.

Structure
REQ-028 SHALL place state enum, NOP constant 32'h00000013, and REG_X0 (5'd0) in shared package pipeline_ctrl_pkg.
REQ-029 SHALL use sub-module hazard_perf_counter (32-bit saturating, inc enable), instantiated three times under HAZ_PERF_CNT_EN.

Verification
REQ-030 EX_mem_read=1, EX_rd=5, ID_rs2=5 -> PC_write=1 one cycle, IF_DWrite=ID_instruction, next cycle PC_write=0 even if inputs unchanged.
REQ-031 EX_rd=0, EX_mem_read=1, ID_rs1=0 -> PC_write never asserts.
REQ-032 DCACHE_stall=1 for 4 cycles, branch_taken pulse target 0x0000_0040 in cycle 1 -> no PC_src until stall drops; then PC_src=IF_flush=1, branch_address=0x40 one cycle.
REQ-033 Two branch pulses (0x40, then 0x80) during stall -> single flush with branch_address=0x80.
REQ-034 Load-use hit and branch_taken same cycle -> IF_flush=1, PC_src=1, PC_write=0.
REQ-035 rst_n low while in BR_PEND -> outputs clear asynchronously; after release no flush issued; with HAZ_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    localparam logic [31:0]      NOP    = 32'h00000013;
    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_PEND  = 2'd2
    } haz_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// 32-bit saturating event counter with increment enable.
module hazard_perf_counter
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and branch redirect control for the fetch stage.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_mem_read,
    input  logic [XLEN-1:0]  ID_instruction,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic             memory_stall,
    output logic             PC_write,
    output logic             IF_flush,
    output logic             PC_src,
    output logic [XLEN-1:0]  branch_address,
    output logic [XLEN-1:0]  IF_DWrite,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    haz_state_t      state, state_nxt;
    logic [XLEN-1:0] pend_addr, pend_addr_nxt;
    logic [XLEN-1:0] lu_inst, lu_inst_nxt;
    logic            lu_hit;

    assign memory_stall = ICACHE_stall | DCACHE_stall;

    assign lu_hit = EX_mem_read && (EX_rd != REG_X0) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

    assign IF_DWrite = PC_write ? ID_instruction : lu_inst;

    // Controls act in the same cycle as their cause; reset forces them quiet.
    always_comb begin
        state_nxt      = state;
        pend_addr_nxt  = pend_addr;
        lu_inst_nxt    = lu_inst;
        PC_write       = 1'b0;
        IF_flush       = 1'b0;
        PC_src         = 1'b0;
        branch_address = '0;
        if (rst_n) begin
            unique case (state)
                RUN, LU_STALL: begin
                    if (branch_taken) begin
                        if (!memory_stall) begin
                            IF_flush       = 1'b1;
                            PC_src         = 1'b1;
                            branch_address = branch_target;
                            state_nxt      = RUN;
                        end else begin
                            pend_addr_nxt = branch_target;
                            state_nxt     = BR_PEND;
                        end
                    end else if (state == RUN) begin
                        if (lu_hit && !memory_stall) begin
                            PC_write    = 1'b1;
                            lu_inst_nxt = ID_instruction;
                            state_nxt   = LU_STALL;
                        end
                    end else if (!memory_stall) begin
                        state_nxt = RUN;
                    end
                end
                BR_PEND: begin
                    if (!memory_stall) begin
                        // A branch resolving in the release cycle is the youngest.
                        IF_flush       = 1'b1;
                        PC_src         = 1'b1;
                        branch_address = branch_taken ? branch_target : pend_addr;
                        pend_addr_nxt  = '0;
                        state_nxt      = RUN;
                    end else if (branch_taken) begin
                        pend_addr_nxt = branch_target;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pend_addr <= '0;
            lu_inst   <= XLEN'(NOP);
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
            lu_inst   <= lu_inst_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    hazard_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (memory_stall),
        .count (perf_stall_cyc)
    );

    hazard_perf_counter u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (PC_write),
        .count (perf_lu_cnt)
    );

    hazard_perf_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (IF_flush),
        .count (perf_flush_cnt)
    );
`else
    assign perf_stall_cyc = '0;
    assign perf_lu_cnt    = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors, negedge monitor.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ICACHE_stall = 1'b0, DCACHE_stall = 1'b0;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic        EX_mem_read = 1'b0;
    logic [31:0] ID_instruction = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        memory_stall, PC_write, IF_flush, PC_src;
    logic [31:0] branch_address, IF_DWrite;
    logic [31:0] perf_stall_cyc, perf_lu_cnt, perf_flush_cnt;

    pipeline_hazard_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ICACHE_stall   (ICACHE_stall),
        .DCACHE_stall   (DCACHE_stall),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .EX_rd          (EX_rd),
        .EX_mem_read    (EX_mem_read),
        .ID_instruction (ID_instruction),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .memory_stall   (memory_stall),
        .PC_write       (PC_write),
        .IF_flush       (IF_flush),
        .PC_src         (PC_src),
        .branch_address (branch_address),
        .IF_DWrite      (IF_DWrite),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_lu_cnt    (perf_lu_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [67:0] val;
        logic        chk_perf;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: one expected record per applied vector, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [67:0] act;
            e   = q.pop_front();
            act = {memory_stall, PC_write, IF_flush, PC_src, branch_address, IF_DWrite};
            n_vec++;
            if (act !== e.val) begin
                n_miss++;
                $display("FAIL %s: got ms/pw/fl/ps=%b%b%b%b ba=%h dw=%h, want ms/pw/fl/ps=%b ba=%h dw=%h",
                         e.nm, act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                         e.val[67:64], e.val[63:32], e.val[31:0]);
            end else if (e.chk_perf &&
                         ({perf_stall_cyc, perf_lu_cnt, perf_flush_cnt} !== 96'd0)) begin
                n_miss++;
                $display("FAIL %s perf: got %h %h %h, want all zero",
                         e.nm, perf_stall_cyc, perf_lu_cnt, perf_flush_cnt);
            end
        end
    end

    // Apply one vector just after posedge and queue the hand-computed outputs.
    task automatic vec(input string nm, input logic r, input logic ic, input logic dc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic [31:0] inst, input logic bt,
                       input logic [31:0] tgt, input logic [3:0] ctl,
                       input logic [31:0] ba, input logic [31:0] dw, input logic chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; ICACHE_stall = ic; DCACHE_stall = dc;
        ID_rs1 = rs1; ID_rs2 = rs2; EX_rd = rd; EX_mem_read = mr;
        ID_instruction = inst; branch_taken = bt; branch_target = tgt;
        e.nm = nm;
        e.val = {ctl, ba, dw};
        e.chk_perf = chk;
        q.push_back(e);
    endtask

    localparam logic [31:0] NOPI = 32'h00000013;
    localparam logic [31:0] LDI  = 32'h00A00093;

    // ctl = {memory_stall, PC_write, IF_flush, PC_src}
    initial begin
        vec("reset",        0,0,0, 0,0,0, 0, 32'hAAAA_AAAA, 0, 0,     4'b0000, 0,     NOPI, 1);
        vec("idle",         1,0,0, 0,0,0, 0, 32'h1111_1111, 0, 0,     4'b0000, 0,     NOPI, 0);
        vec("lu_hit_rs2",   1,0,0, 1,5,5, 1, LDI,           0, 0,     4'b0100, 0,     LDI,  0);
        vec("lu_masked",    1,0,0, 1,5,5, 1, LDI,           0, 0,     4'b0000, 0,     LDI,  0);
        vec("lu_held",      1,0,0, 0,0,0, 0, 32'h3333_3333, 0, 0,     4'b0000, 0,     LDI,  0);
        vec("x0_no_hit_a",  1,0,0, 0,0,0, 1, 32'h4444_4444, 0, 0,     4'b0000, 0,     LDI,  0);
        vec("x0_no_hit_b",  1,0,0, 0,0,0, 1, 32'h4444_4444, 0, 0,     4'b0000, 0,     LDI,  0);
        vec("br_stall_1",   1,0,1, 0,0,0, 0, 0,             1, 32'h40,4'b1000, 0,     LDI,  0);
        vec("br_stall_2",   1,0,1, 0,0,0, 0, 0,             0, 0,     4'b1000, 0,     LDI,  0);
        vec("br_stall_3",   1,0,1, 0,0,0, 0, 0,             0, 0,     4'b1000, 0,     LDI,  0);
        vec("br_stall_4",   1,0,1, 0,0,0, 0, 0,             0, 0,     4'b1000, 0,     LDI,  0);
        vec("br_release",   1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0011, 32'h40,LDI,  0);
        vec("br_once",      1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0000, 0,     LDI,  0);
        vec("br2_first",    1,0,1, 0,0,0, 0, 0,             1, 32'h40,4'b1000, 0,     LDI,  0);
        vec("br2_second",   1,0,1, 0,0,0, 0, 0,             1, 32'h80,4'b1000, 0,     LDI,  0);
        vec("br2_wait",     1,0,1, 0,0,0, 0, 0,             0, 0,     4'b1000, 0,     LDI,  0);
        vec("br2_release",  1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0011, 32'h80,LDI,  0);
        vec("br2_once",     1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0000, 0,     LDI,  0);
        vec("br_beats_lu",  1,0,0, 7,0,7, 1, 32'h4444_0044, 1, 32'h100,4'b0011,32'h100,LDI, 0);
        vec("after_br_lu",  1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0000, 0,     LDI,  0);
        vec("lu_in_istall", 1,1,0, 3,0,3, 1, 32'h5555_0055, 0, 0,     4'b1000, 0,     LDI,  0);
        vec("lu_after_is",  1,0,0, 3,0,3, 1, 32'h5555_0055, 0, 0,     4'b0100, 0,     32'h5555_0055, 0);
        vec("lus_hold",     1,1,0, 3,0,3, 1, 32'h5555_0055, 0, 0,     4'b1000, 0,     32'h5555_0055, 0);
        vec("lus_exit",     1,0,0, 3,0,3, 1, 32'h5555_0055, 0, 0,     4'b0000, 0,     32'h5555_0055, 0);
        vec("pend_for_rst", 1,0,1, 0,0,0, 0, 0,             1, 32'hC0,4'b1000, 0,     32'h5555_0055, 0);
        vec("rst_in_pend",  0,0,0, 0,0,0, 0, 32'h6666_6666, 0, 0,     4'b0000, 0,     NOPI, 1);
        vec("rst_ms_live",  0,1,0, 0,0,0, 0, 0,             1, 32'h99,4'b1000, 0,     NOPI, 1);
        vec("rst_release",  1,0,0, 0,0,0, 0, 0,             0, 0,     4'b0000, 0,     NOPI, 1);
        vec("br_direct",    1,0,0, 0,0,0, 0, 0,             1, 32'h200,4'b0011,32'h200,NOPI,0);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected records never compared", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
